// File: rtl/sparhixcel_result_writer_pkg.sv
// sparhixcel_pkg: shared types and constants for the SparHiXcel result writer.
//   res_wr_state_t  : writer FSM states (IDLE / ACC / DRAIN / DONE)
//   RES_WIDTH_DEF   : default width of one array column result
//   ACC_WIDTH_DEF   : default accumulator / output word width
//   sat_max/sat_min : signed bounds of a two's-complement word of a given width,
//                     used by the optional accumulator saturation
package sparhixcel_pkg;

  localparam int RES_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF = 19;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'd0,
    RW_ACC   = 2'd1,
    RW_DRAIN = 2'd2,
    RW_DONE  = 2'd3
  } res_wr_state_t;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sparhixcel_result_writer_if.sv
// sparhixcel_result_writer_if: valid/ready write port into the output feature
// memory.
//   wr_en_o    : write valid (writer -> memory)
//   wr_ready_i : memory ready (memory -> writer)
//   wr_addr_o  : write address
//   wr_data_o  : signed write data
// Modports: master = result writer, slave = output memory.
interface sparhixcel_result_writer_if
  import sparhixcel_pkg::*;
#(
  parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH = 6
);

  logic                        wr_en_o;
  logic                        wr_ready_i;
  logic [OUT_ADDR_WIDTH-1:0]   wr_addr_o;
  logic signed [ACC_WIDTH-1:0] wr_data_o;

  modport master (
    output wr_en_o,
    output wr_addr_o,
    output wr_data_o,
    input  wr_ready_i
  );

  modport slave (
    input  wr_en_o,
    input  wr_addr_o,
    input  wr_data_o,
    output wr_ready_i
  );

endinterface

// File: rtl/sparhixcel_result_writer_acc_lane.sv
// result_acc_lane: one column accumulator of the result writer.
//   clk_i, general_rst_i : clock, asynchronous active-high reset
//   clear_i              : zero the accumulator (wins over load_i)
//   load_i               : store acc_nxt_o into the accumulator
//   from_zero_i          : add the result to 0 instead of the held value
//   result_i             : signed column result, sign-extended before the add
//   acc_o                : held accumulator value
//   acc_nxt_o            : value that load_i would store
// Build option: SPARHIXCEL_ACC_SAT_EN defined -> the add saturates to the
// ACC_WIDTH signed range; undefined -> the add wraps in two's complement.
module result_acc_lane
  import sparhixcel_pkg::*;
#(
  parameter int RES_WIDTH = RES_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        general_rst_i,
  input  logic                        clear_i,
  input  logic                        load_i,
  input  logic                        from_zero_i,
  input  logic signed [RES_WIDTH-1:0] result_i,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic signed [ACC_WIDTH-1:0] acc_nxt_o
);

  logic signed [ACC_WIDTH-1:0] base;

  assign base = from_zero_i ? '0 : acc_o;

`ifdef SPARHIXCEL_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

  logic signed [ACC_WIDTH:0] sum_w;

  // One guard bit: overflow shows as the two top bits disagreeing, and the
  // guard bit then gives the true sign of the result.
  always_comb begin
    sum_w     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(result_i);
    acc_nxt_o = sum_w[ACC_WIDTH-1:0];
    if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
      acc_nxt_o = sum_w[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    acc_nxt_o = base + ACC_WIDTH'(result_i);
  end
`endif

  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      acc_o <= '0;
    end else if (clear_i) begin
      acc_o <= '0;
    end else if (load_i) begin
      acc_o <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/sparhixcel_result_writer.sv
// sparhixcel_result_writer: output-side drain of the SparHiXcel systolic array.
// Accumulates per-column results over weight rounds, then writes the column
// sums one word per transfer into the output feature memory.
//   clk_i, general_rst_i : clock, asynchronous active-high reset
//   result_i             : per-column signed array results
//   capture_i            : result_i valid this cycle
//   last_round_i         : this capture is the final weight round
//   addr_clr_i           : clear the write address (honoured in IDLE only)
//   wr                   : write port (wr_en_o, wr_ready_i, wr_addr_o, wr_data_o)
//   busy_o               : draining or finishing
//   done_o               : one-cycle pulse at drain completion
//   capture_err_o        : sticky, a capture arrived while busy and was dropped
// Build option SPARHIXCEL_ACC_SAT_EN: saturating accumulators (see lane).
module sparhixcel_result_writer
  import sparhixcel_pkg::*;
#(
  parameter int N_COLS_ARRAY   = 4,
  parameter int RES_WIDTH      = RES_WIDTH_DEF,
  parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH = 6
) (
  input  logic                        clk_i,
  input  logic                        general_rst_i,
  input  logic signed [RES_WIDTH-1:0] result_i [N_COLS_ARRAY],
  input  logic                        capture_i,
  input  logic                        last_round_i,
  input  logic                        addr_clr_i,
  sparhixcel_result_writer_if.master  wr,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        capture_err_o
);

  localparam int COL_W = (N_COLS_ARRAY > 1) ? $clog2(N_COLS_ARRAY) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS_ARRAY - 1);

  res_wr_state_t               state_q, state_d;
  logic [COL_W-1:0]            col_q, col_d, col_inc;
  logic [OUT_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                        wr_en_q, wr_en_d;
  logic signed [ACC_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic                        lane_load, lane_clear, lane_from_zero;
  logic signed [ACC_WIDTH-1:0] acc     [N_COLS_ARRAY];
  logic signed [ACC_WIDTH-1:0] acc_nxt [N_COLS_ARRAY];

  for (genvar c = 0; c < N_COLS_ARRAY; c++) begin : g_lane
    result_acc_lane #(
      .RES_WIDTH(RES_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk_i        (clk_i),
      .general_rst_i(general_rst_i),
      .clear_i      (lane_clear),
      .load_i       (lane_load),
      .from_zero_i  (lane_from_zero),
      .result_i     (result_i[c]),
      .acc_o        (acc[c]),
      .acc_nxt_o    (acc_nxt[c])
    );
  end

  assign col_inc = col_q + 1'b1;

  // wr_data is a flop, so the word for the next transfer is preloaded one
  // edge ahead: the freshly loaded lane-0 sum on the last capture, then the
  // following column on each accepted transfer. A stall leaves it untouched.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    addr_d         = addr_q;
    wr_en_d        = wr_en_q;
    wr_data_d      = wr_data_q;
    done_d         = 1'b0;
    err_d          = err_q;
    lane_load      = 1'b0;
    lane_clear     = 1'b0;
    lane_from_zero = (state_q == RW_IDLE);

    unique case (state_q)
      RW_IDLE, RW_ACC: begin
        if (state_q == RW_IDLE && addr_clr_i) begin
          addr_d = '0;
        end
        if (capture_i) begin
          lane_load = 1'b1;
          if (last_round_i) begin
            state_d   = RW_DRAIN;
            col_d     = '0;
            wr_en_d   = 1'b1;
            wr_data_d = acc_nxt[0];
          end else begin
            state_d = RW_ACC;
          end
        end
      end
      RW_DRAIN: begin
        if (capture_i) begin
          err_d = 1'b1;
        end
        if (wr.wr_ready_i) begin
          addr_d = addr_q + 1'b1;
          if (col_q == LAST_COL) begin
            state_d   = RW_DONE;
            col_d     = '0;
            wr_en_d   = 1'b0;
            wr_data_d = '0;
            done_d    = 1'b1;
          end else begin
            col_d     = col_inc;
            wr_data_d = acc[col_inc];
          end
        end
      end
      RW_DONE: begin
        if (capture_i) begin
          err_d = 1'b1;
        end
        lane_clear = 1'b1;
        state_d    = RW_IDLE;
      end
      default: state_d = RW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      state_q   <= RW_IDLE;
      col_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr.wr_en_o    = wr_en_q;
  assign wr.wr_addr_o  = addr_q;
  assign wr.wr_data_o  = wr_data_q;
  assign busy_o        = (state_q == RW_DRAIN) || (state_q == RW_DONE);
  assign done_o        = done_q;
  assign capture_err_o = err_q;

endmodule

// File: tb/tb_sparhixcel_result_writer.sv
module tb_sparhixcel_result_writer;

  typedef struct packed {
    logic [1:0]        rounds;
    logic [3:0][15:0]  res;
    logic [3:0][18:0]  exp;
    logic [1:0]        stall_col;
    logic [2:0]        stall_n;
    logic              cap_busy;
    logic              clr_busy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // DUT A: default geometry (4 columns, 19-bit accumulators)
  logic              a_rst = 1'b0;
  logic signed [15:0] a_res [4];
  logic              a_cap = 1'b0, a_last = 1'b0, a_clr = 1'b0;
  logic              a_busy, a_done, a_err;
  logic [5:0]        a_exp_addr = '0;
  logic              a_exp_err = 1'b0;

  sparhixcel_result_writer_if #(.ACC_WIDTH(19), .OUT_ADDR_WIDTH(6)) a_wr ();

  sparhixcel_result_writer #(
    .N_COLS_ARRAY(4), .RES_WIDTH(16), .ACC_WIDTH(19), .OUT_ADDR_WIDTH(6)
  ) u_dut_a (
    .clk_i(clk), .general_rst_i(a_rst), .result_i(a_res), .capture_i(a_cap),
    .last_round_i(a_last), .addr_clr_i(a_clr), .wr(a_wr),
    .busy_o(a_busy), .done_o(a_done), .capture_err_o(a_err)
  );

  // DUT B: 3 columns, 16-bit accumulators (overflow and address clear)
  logic              b_rst = 1'b0;
  logic signed [15:0] b_res [3];
  logic              b_cap = 1'b0, b_last = 1'b0, b_clr = 1'b0;
  logic              b_busy, b_done, b_err;
  logic [5:0]        b_exp_addr = '0;

  sparhixcel_result_writer_if #(.ACC_WIDTH(16), .OUT_ADDR_WIDTH(6)) b_wr ();

  sparhixcel_result_writer #(
    .N_COLS_ARRAY(3), .RES_WIDTH(16), .ACC_WIDTH(16), .OUT_ADDR_WIDTH(6)
  ) u_dut_b (
    .clk_i(clk), .general_rst_i(b_rst), .result_i(b_res), .capture_i(b_cap),
    .last_round_i(b_last), .addr_clr_i(b_clr), .wr(b_wr),
    .busy_o(b_busy), .done_o(b_done), .capture_err_o(b_err)
  );

  vec_t vecs [4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input int rounds, input int r0, input int r1, input int r2,
                              input int r3, input int e0, input int e1, input int e2,
                              input int e3, input int stall_col, input int stall_n,
                              input bit cap_busy, input bit clr_busy);
    vec_t m;
    m.rounds    = 2'(rounds);
    m.res[0]    = 16'(r0); m.res[1] = 16'(r1); m.res[2] = 16'(r2); m.res[3] = 16'(r3);
    m.exp[0]    = 19'(e0); m.exp[1] = 19'(e1); m.exp[2] = 19'(e2); m.exp[3] = 19'(e3);
    m.stall_col = 2'(stall_col);
    m.stall_n   = 3'(stall_n);
    m.cap_busy  = cap_busy;
    m.clr_busy  = clr_busy;
    return m;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after DONE (IDLE again).
  task automatic run_a(input vec_t v);
    int  col, cycles, stalls;
    bit  stall;
    for (int r = 0; r < int'(v.rounds); r++) begin
      for (int c = 0; c < 4; c++) a_res[c] = v.res[c];
      a_cap  = 1'b1;
      a_last = (r == int'(v.rounds) - 1);
      @(negedge clk);
    end
    a_cap = 1'b0; a_last = 1'b0;
    col = 0; cycles = 0; stalls = int'(v.stall_n);
    while (col < 4 && cycles < 40) begin
      chk("a_wr_en", longint'(a_wr.wr_en_o), 1);
      chk("a_wr_addr", longint'(a_wr.wr_addr_o), longint'(a_exp_addr));
      chk("a_wr_data", longint'($signed(a_wr.wr_data_o)), longint'($signed(v.exp[col])));
      stall = (col == int'(v.stall_col)) && (stalls > 0);
      a_wr.wr_ready_i = !stall;
      if (v.cap_busy && col == 2) begin
        for (int c = 0; c < 4; c++) a_res[c] = 16'sd1111;
        a_cap = 1'b1; a_last = 1'b1; a_exp_err = 1'b1;
      end
      if (v.clr_busy && col == 1) a_clr = 1'b1;
      if (stall) stalls--;
      else begin col++; a_exp_addr++; end
      cycles++;
      @(negedge clk);
      a_cap = 1'b0; a_last = 1'b0; a_clr = 1'b0;
    end
    a_wr.wr_ready_i = 1'b1;
    chk("a_drain_cycles", cycles, 4 + int'(v.stall_n));
    chk("a_done_pulse", longint'(a_done), 1);
    chk("a_busy_done", longint'(a_busy), 1);
    chk("a_wr_en_after", longint'(a_wr.wr_en_o), 0);
    chk("a_capture_err", longint'(a_err), longint'(a_exp_err));
    @(negedge clk);
    chk("a_done_single", longint'(a_done), 0);
    chk("a_busy_idle", longint'(a_busy), 0);
  endtask

  task automatic run_b(input int rounds, input int r0, input int r1, input int r2,
                       input int e0, input int e1, input int e2);
    int exp_v [3];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
    b_res[0] = 16'(r0); b_res[1] = 16'(r1); b_res[2] = 16'(r2);
    for (int r = 0; r < rounds; r++) begin
      b_cap  = 1'b1;
      b_last = (r == rounds - 1);
      @(negedge clk);
    end
    b_cap = 1'b0; b_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("b_wr_en", longint'(b_wr.wr_en_o), 1);
      chk("b_wr_addr", longint'(b_wr.wr_addr_o), longint'(b_exp_addr));
      chk("b_wr_data", longint'($signed(b_wr.wr_data_o)), longint'(exp_v[c]));
      b_exp_addr++;
      @(negedge clk);
    end
    chk("b_done_pulse", longint'(b_done), 1);
    @(negedge clk);
    chk("b_busy_idle", longint'(b_busy), 0);
  endtask

  initial begin
    int b_e0, b_e2;
    for (int c = 0; c < 4; c++) a_res[c] = '0;
    for (int c = 0; c < 3; c++) b_res[c] = '0;
    a_wr.wr_ready_i = 1'b1;
    b_wr.wr_ready_i = 1'b1;

    vecs[0] = mk(1, 5, -3, 100, 0,        5, -3, 100, 0,           0, 0, 1'b0, 1'b0);
    vecs[1] = mk(3, 1, 2, 3, 4,           3, 6, 9, 12,             0, 0, 1'b0, 1'b0);
    vecs[2] = mk(1, 10, 20, 30, 40,       10, 20, 30, 40,          1, 3, 1'b0, 1'b0);
    vecs[3] = mk(2, -7, 32767, -32768, 1000, -14, 65534, -65536, 2000, 0, 0, 1'b1, 1'b1);

    // Reset
    #1 a_rst = 1'b1; b_rst = 1'b1;
    #1;
    chk("rst_wr_en", longint'(a_wr.wr_en_o), 0);
    chk("rst_wr_addr", longint'(a_wr.wr_addr_o), 0);
    chk("rst_wr_data", longint'($signed(a_wr.wr_data_o)), 0);
    chk("rst_busy", longint'(a_busy), 0);
    chk("rst_done", longint'(a_done), 0);
    chk("rst_err", longint'(a_err), 0);
    repeat (2) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_en", longint'(a_wr.wr_en_o), 0);

    // Table: single round, three rounds, backpressure, capture while busy
    for (int i = 0; i < 4; i++) run_a(vecs[i]);

    // Reset mid-drain after two writes
    for (int c = 0; c < 4; c++) a_res[c] = vecs[0].res[c];
    a_cap = 1'b1; a_last = 1'b1;
    @(negedge clk);
    a_cap = 1'b0; a_last = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("mid_wr_en", longint'(a_wr.wr_en_o), 1);
      chk("mid_wr_addr", longint'(a_wr.wr_addr_o), longint'(a_exp_addr));
      a_exp_addr++;
      @(negedge clk);
    end
    a_rst = 1'b1;
    #1;
    chk("arst_wr_en", longint'(a_wr.wr_en_o), 0);
    chk("arst_wr_addr", longint'(a_wr.wr_addr_o), 0);
    chk("arst_wr_data", longint'($signed(a_wr.wr_data_o)), 0);
    chk("arst_busy", longint'(a_busy), 0);
    chk("arst_err", longint'(a_err), 0);
    #1 a_rst = 1'b0;
    a_exp_addr = '0; a_exp_err = 1'b0;
    @(negedge clk);
    chk("arst_idle_wr_en", longint'(a_wr.wr_en_o), 0);
    chk("arst_idle_busy", longint'(a_busy), 0);
    run_a(vecs[0]);

    // Overflow on 16-bit accumulators
`ifdef SPARHIXCEL_ACC_SAT_EN
    b_e0 = 32767; b_e2 = -32768;
`else
    b_e0 = -2;    b_e2 = 0;
`endif
    run_b(2, 32767, 1, -32768, b_e0, 2, b_e2);
    run_b(1, 1, 2, 3, 1, 2, 3);
    run_b(1, -4, 0, 7, -4, 0, 7);
    chk("b_addr_before_clr", longint'(b_wr.wr_addr_o), 9);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk("b_addr_after_clr", longint'(b_wr.wr_addr_o), 0);
    chk("b_capture_err", longint'(b_err), 0);
    b_exp_addr = '0;
    run_b(1, 4, 5, 6, 4, 5, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
